imem_program_loader: RTL

// - Writes programs into instruction memory. Uses the IMEM write port (im_wr) that the control unit never drives.
// - Receives a framed byte stream on a valid/ready interface and writes each payload byte to IMEM.
// - Holds the core in reset while loading, then releases it.
// - Watches end_op from the control unit to report that the program has finished.

---
 rtl/imem_program_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/imem_program_loader.sv
// Loads a framed byte stream (SYNC, LEN, payload) into IMEM while holding the core in reset.
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that must match before release.
module imem_program_loader #(
    parameter int unsigned       ADDR_W     = 8,
    parameter logic [7:0]        SYNC_BYTE  = 8'hA5,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              im_wr,
    output logic              core_rst_n,
    input  logic              end_op,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        byte_count
);
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_START, S_RUN, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nx;
    logic              acc;
    logic              is_sync;
    logic              len_bad;
    logic              last_byte;
    logic [7:0]        len_q;
    logic [ADDR_W-1:0] wr_ptr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign acc       = rx_valid && rx_ready;
    assign is_sync   = (rx_data == SYNC_BYTE);
    assign len_bad   = (rx_data == 8'd0) || ({25'd0, rx_data} > DEPTH);
    assign last_byte = ((byte_count + 8'd1) == len_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (acc && is_sync) state_nx = S_LEN;
            S_LEN:                 if (acc) state_nx = len_bad ? S_ERR : S_DATA;
`ifdef LOADER_CHECKSUM_EN
            S_DATA:                if (acc && last_byte) state_nx = S_CSUM;
            S_CSUM:                if (acc) state_nx = (rx_data == csum) ? S_START : S_ERR;
`else
            S_DATA:                if (acc && last_byte) state_nx = S_START;
`endif
            S_START:               state_nx = S_RUN;
            S_RUN:                 if (end_op) state_nx = S_DONE;
            default:               state_nx = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ready   <= 1'b0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            im_wr      <= 1'b0;
            im_addr    <= START_ADDR;
            im_wdata   <= 8'd0;
            byte_count <= 8'd0;
        end else begin
            rx_ready   <= !(state_nx inside {S_START, S_RUN});
            core_rst_n <= (state_nx inside {S_RUN, S_DONE});
            busy       <= (state_nx inside {S_LEN, S_DATA, S_CSUM, S_START});
            load_done  <= (state_nx == S_DONE);
            load_err   <= (state_nx == S_ERR);
            im_wr      <= acc && (state == S_DATA);
            if (acc && (state == S_DATA)) begin
                im_addr    <= wr_ptr;
                im_wdata   <= rx_data;
                byte_count <= byte_count + 8'd1;
            end else if (acc && (state == S_LEN) && !len_bad) begin
                byte_count <= 8'd0;
            end
        end
    end

    // Frame bookkeeping; always re-initialised on a good LEN byte, so no reset needed.
    always_ff @(posedge clk) begin
        if (acc && (state == S_LEN)) begin
            len_q  <= rx_data;
            wr_ptr <= START_ADDR;
`ifdef LOADER_CHECKSUM_EN
            csum   <= 8'd0;
`endif
        end else if (acc && (state == S_DATA)) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
            csum   <= csum ^ rx_data;
`endif
        end
    end

endmodule
